// File: rtl/sdiv_pkg.sv
// Shared types and limits for the iterative divider (sdiv_iter).
package sdiv_pkg;

    localparam int unsigned MIN_WIDTH = 4;
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } sdiv_state_e;

    typedef struct packed {
        logic div_by_zero;
        logic overflow;
    } sdiv_status_t;

endpackage

// File: rtl/sdiv_clz.sv
// Combinational leading-zero count; all-zero input reports WIDTH.
module sdiv_clz
    import sdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]               a_i,
    output logic [$clog2(WIDTH+1)-1:0]     zeros_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Ascending scan: the highest set bit is the last one to write the result.
    always_comb begin
        zeros_c = CNT_W'(WIDTH);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (a_i[i]) begin
                zeros_c = CNT_W'(int'(WIDTH) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/sdiv_iter.sv
// Iterative restoring divider, signed/unsigned per operation, one quotient bit per cycle.
// Optional macro SDIV_EARLY_TERM_EN skips leading-zero iterations of the dividend.
module sdiv_iter
    import sdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    sdiv_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             signed_q, signed_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    sdiv_status_t     status_q, status_d;
    logic             in_ready_q, out_valid_q, busy_q;

    logic             sd, sv, is_zero, is_ovf;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH+1:0] shifted, diff;

    assign sd      = signed_q & a_q[WIDTH-1];
    assign sv      = signed_q & b_q[WIDTH-1];
    assign abs_a   = sd ? (-a_q) : a_q;
    assign abs_b   = sv ? (-b_q) : b_q;
    assign is_zero = (b_q == '0);
    assign is_ovf  = signed_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

    // Partial remainder is always below the divisor, so the extra top bit acts as the sign.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

`ifdef SDIV_EARLY_TERM_EN
    logic [CNT_W-1:0] clz_z;

    sdiv_clz #(
        .WIDTH (WIDTH)
    ) u_clz (
        .a_i     (abs_a),
        .zeros_c (clz_z)
    );
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        signed_d    = signed_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        status_d    = status_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d      = dividend;
                    b_d      = divisor;
                    signed_d = in_signed;
                    state_d  = PREP;
                end
            end
            PREP: begin
                qneg_d  = sd ^ sv;
                rneg_d  = sd;
                rem_d   = '0;
                dvs_d   = {1'b0, abs_b};
`ifdef SDIV_EARLY_TERM_EN
                dvd_d   = abs_a << clz_z;
                cnt_d   = CNT_W'(WIDTH) - clz_z;
                state_d = (clz_z == CNT_W'(WIDTH)) ? FIX : ITER;
`else
                dvd_d   = abs_a;
                cnt_d   = CNT_W'(WIDTH);
                state_d = ITER;
`endif
                if (is_zero) begin
                    quotient_d           = '1;
                    remainder_d          = a_q;
                    status_d.div_by_zero = 1'b1;
                    state_d              = DONE;
                end else if (is_ovf) begin
                    quotient_d        = a_q;
                    remainder_d       = '0;
                    status_d.overflow = 1'b1;
                    state_d           = DONE;
                end
            end
            ITER: begin
                rem_d = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
                dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH+1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = qneg_q ? (-dvd_q) : dvd_q;
                remainder_d = rneg_q ? (-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    status_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dvd_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            status_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            signed_q    <= signed_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            status_q    <= status_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = status_q.div_by_zero;
    assign overflow    = status_q.overflow;

endmodule

// File: tb/tb_sdiv_iter.sv
// Scoreboard bench for sdiv_iter (WIDTH=32); honours SDIV_EARLY_TERM_EN for latency expectations.
module tb_sdiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sdiv_iter #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: native SV division truncates toward zero, remainder follows dividend sign.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint sa;
        longint sbv;
`ifdef SDIV_EARLY_TERM_EN
        logic [31:0] mag;
        int          z;
        mag = (s && a[31]) ? (-a) : a;
        z   = 32;
        for (int i = 0; i < 32; i++) if (mag[i]) z = 31 - i;
        e.lat = 32 - z + 3;
`else
        e.lat = 35;
`endif
        e.q  = '0;
        e.r  = '0;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 2;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q   = a;
            e.ov  = 1'b1;
            e.lat = 2;
        end else if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            e.q = 32'(sa / sbv);
            e.r = 32'(sa % sbv);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
        exp_t e;
        int   lat;
        int   w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        in_signed = s;
        sb.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        chk("busy_after_accept", 64'(busy), 64'd1);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            chk("out_valid_timeout", 64'(out_valid), 64'd1);
            return;
        end
        chk("quotient", 64'(quotient), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        chk("overflow", 64'(overflow), 64'(e.ov));
        chk("latency", 64'(lat), 64'(e.lat));
        // Back-pressure: result frozen, requests while busy must be ignored.
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            dividend  = $urandom;
            divisor   = $urandom;
            in_signed = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_quotient", 64'(quotient), 64'(e.q));
            chk("hold_remainder", 64'(remainder), 64'(e.r));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_busy", 64'(busy), 64'd0);
        chk("release_flags", 64'({div_by_zero, overflow}), 64'd0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        do_op(32'd100, 32'd7, 1'b1, 0);
        do_op(32'(-100), 32'd7, 1'b1, 0);
        do_op(32'd100, 32'(-7), 1'b1, 0);
        do_op(32'(-100), 32'(-7), 1'b1, 0);
        do_op(32'hFFFF_FFFF, 32'd2, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'd2, 1'b1, 0);
        do_op(32'd55, 32'd0, 1'b0, 0);
        do_op(32'(-5), 32'd0, 1'b1, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(32'h8000_0000, 32'd3, 1'b1, 0);
        do_op(32'd0, 32'd9, 1'b0, 0);
        do_op(32'd5, 32'd1, 1'b0, 0);
        do_op(32'd100, 32'd7, 1'b1, 10);

        // Reset while iterating discards the operation.
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        in_signed = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        do_op(32'd9, 32'd3, 1'b0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(0, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) a = a >> $urandom_range(0, 31);
            do_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
